// File: rtl/led_ctrl.sv
// rtl/led_ctrl.sv - status LED controller: heartbeat, activity flash and error blink on one pin
module led_ctrl #(
    parameter int       TICK_DIV     = 50000,
    parameter int       HB_PERIOD    = 1000,
    parameter int       HB_ON        = 100,
    parameter int       ACT_ON       = 50,
    parameter int       ACT_OFF      = 50,
    parameter int       ERR_HALF     = 125,
    parameter bit       LED_ON_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       err,
    input  logic       act,
    output logic       led,
    output logic [1:0] state
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic          LED_ON    = LED_ON_LEVEL;
    localparam logic          LED_OFF   = ~LED_ON_LEVEL;
    localparam logic [15:0]   HB_LAST   = 16'(HB_PERIOD - 1);
    localparam logic [15:0]   HB_ON_W   = 16'(HB_ON);
    localparam logic [15:0]   ACT_ON_W  = 16'(ACT_ON);
    localparam logic [15:0]   ACT_LAST  = 16'(ACT_ON + ACT_OFF - 1);
    localparam logic [15:0]   ERR_LAST  = 16'(ERR_HALF - 1);

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_HB  = 2'd1,
        S_ACT = 2'd2,
        S_ERR = 2'd3
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [15:0]   r_phase;
    logic          r_led;
    logic          r_pend;

    state_t        w_state_n;
    logic [PW-1:0] w_presc_n;
    logic [15:0]   w_phase_n;
    logic          w_led_n;
    logic          w_pend_n;
    logic          w_tick;
    logic          w_enter;
    logic [15:0]   w_phase_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_presc <= '0;
            r_phase <= '0;
            r_led   <= LED_OFF;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_presc <= w_presc_n;
            r_phase <= w_phase_n;
            r_led   <= w_led_n;
            r_pend  <= w_pend_n;
        end
    end

    // The led register is loaded with the level belonging to the *next* phase,
    // so the pin changes on the same edge the phase counter does.
    always_comb begin
        w_tick      = (r_presc == PRESC_MAX);
        w_phase_inc = r_phase + 16'd1;
        w_state_n   = r_state;
        w_presc_n   = w_tick ? '0 : r_presc + PW'(1);
        w_phase_n   = r_phase;
        w_led_n     = r_led;
        w_pend_n    = r_pend;
        w_enter     = 1'b0;

        if (!en) begin
            w_state_n = S_OFF;
            w_enter   = 1'b1;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_n = S_HB;
                    w_enter   = 1'b1;
                end
                S_HB: begin
                    if (err) begin
                        w_state_n = S_ERR;
                        w_enter   = 1'b1;
                    end else if (act) begin
                        w_state_n = S_ACT;
                        w_enter   = 1'b1;
                    end else begin
                        if (w_tick)
                            w_phase_n = (r_phase == HB_LAST) ? 16'd0 : w_phase_inc;
                        w_led_n = (w_phase_n < HB_ON_W) ? LED_ON : LED_OFF;
                    end
                end
                S_ACT: begin
                    if (err) begin
                        w_state_n = S_ERR;
                        w_enter   = 1'b1;
                    end else if (w_tick && r_phase == ACT_LAST) begin
                        // A pulse landing on the final edge counts as pending too.
                        w_state_n = (r_pend || act) ? S_ACT : S_HB;
                        w_enter   = 1'b1;
                    end else begin
                        w_pend_n = r_pend | act;
                        if (w_tick)
                            w_phase_n = w_phase_inc;
                        w_led_n = (w_phase_n < ACT_ON_W) ? LED_ON : LED_OFF;
                    end
                end
                S_ERR: begin
                    if (!err) begin
                        w_state_n = S_HB;
                        w_enter   = 1'b1;
                    end else if (w_tick) begin
                        if (r_phase == ERR_LAST) begin
                            w_phase_n = 16'd0;
                            w_led_n   = ~r_led;
                        end else begin
                            w_phase_n = w_phase_inc;
                        end
                    end
                end
                default: begin
                    w_state_n = S_OFF;
                    w_enter   = 1'b1;
                end
            endcase
        end

        if (w_enter) begin
            w_presc_n = '0;
            w_phase_n = 16'd0;
            w_pend_n  = 1'b0;
            w_led_n   = (w_state_n == S_OFF) ? LED_OFF : LED_ON;
        end
    end

    assign led   = r_led;
    assign state = r_state;

endmodule

// File: tb/tb_led_ctrl.sv
// tb/tb_led_ctrl.sv - randomized and directed checks of led_ctrl against a time-since-entry model
module tb_led_ctrl;

    localparam int TD  = 4;
    localparam int HBP = 10;
    localparam int HBN = 2;
    localparam int AON = 3;
    localparam int AOF = 2;
    localparam int EH  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       err = 1'b0;
    logic       act = 1'b0;
    logic       led;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: state, cycles elapsed since state entry, pending flag.
    int m_state = 0;
    int m_t     = 0;
    bit m_pend  = 1'b0;

    led_ctrl #(
        .TICK_DIV(TD), .HB_PERIOD(HBP), .HB_ON(HBN),
        .ACT_ON(AON), .ACT_OFF(AOF), .ERR_HALF(EH), .LED_ON_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .err(err), .act(act),
        .led(led), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic enter(input int s);
        m_state = s;
        m_t     = 0;
        m_pend  = 1'b0;
    endtask

    task automatic model_edge();
        if (rst || !en) begin
            enter(0);
        end else begin
            case (m_state)
                0: enter(1);
                1: if (err) enter(3); else if (act) enter(2); else m_t++;
                2: begin
                    if (err) enter(3);
                    else if (m_t + 1 == TD * (AON + AOF)) enter((m_pend || act) ? 2 : 1);
                    else begin m_pend = m_pend | act; m_t++; end
                end
                default: if (!err) enter(1); else m_t++;
            endcase
        end
    endtask

    // LED_ON_LEVEL is 0: lit -> pin 0.
    function automatic int model_led();
        bit lit;
        case (m_state)
            0:       lit = 1'b0;
            1:       lit = ((m_t / TD) % HBP) < HBN;
            2:       lit = (m_t / TD) < AON;
            default: lit = ((m_t / (TD * EH)) % 2) == 0;
        endcase
        return lit ? 0 : 1;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("state", int'(state), m_state);
        check_eq("led", int'(led), model_led());
    endtask

    task automatic pulse_act();
        act = 1'b1;
        step();
        act = 1'b0;
    endtask

    int cnt;

    initial begin
        rst = 1'b1; en = 1'b1; err = 1'b1; act = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_state", int'(state), 0);
            check_eq("rst_led", int'(led), 1);
        end
        rst = 1'b0;
        step();
        check_eq("release_state", int'(state), 1);
        check_eq("release_led", int'(led), 0);
        step();
        check_eq("hb_to_err", int'(state), 3);
        for (int i = 0; i < 20; i++) step();

        // Heartbeat: 16 lit cycles in two 40-cycle periods from entry.
        err = 1'b0;
        step();
        cnt = (led == 1'b0) ? 1 : 0;
        for (int i = 1; i < 80; i++) begin
            step();
            if (led == 1'b0) cnt++;
        end
        check_eq("hb_lit_cycles", cnt, 16);

        // Single flash: 20 cycles in ACT, then HB with led lit.
        pulse_act();
        cnt = 0;
        for (int i = 0; i < 100 && state == 2'd2; i++) begin
            cnt++;
            step();
        end
        check_eq("act_single_len", cnt, 20);
        check_eq("act_single_exit", int'(state), 1);
        check_eq("act_single_exit_led", int'(led), 0);

        // Three pulses within one flash -> exactly one repeat.
        for (int i = 0; i < 7; i++) step();
        pulse_act();
        cnt = 1;
        for (int i = 0; i < 200 && state == 2'd2; i++) begin
            if (i == 2 || i == 5 || i == 9) act = 1'b1;
            step();
            act = 1'b0;
            if (state == 2'd2) cnt++;
        end
        check_eq("act_repeat_len", cnt, 40);
        check_eq("act_repeat_exit", int'(state), 1);

        // Error during ACT with pending set; no replay afterwards.
        pulse_act();
        step();
        pulse_act();
        err = 1'b1;
        step();
        check_eq("act_to_err", int'(state), 3);
        for (int i = 0; i < 24; i++) begin
            act = (i % 5 == 0);
            step();
        end
        act = 1'b0;
        err = 1'b0;
        step();
        check_eq("err_to_hb", int'(state), 1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (state != 2'd1) cnt++;
        end
        check_eq("no_act_replay", cnt, 0);

        // en=0 with err in ERR, then re-enable.
        err = 1'b1;
        step();
        step();
        en = 1'b0;
        step();
        check_eq("disable_state", int'(state), 0);
        check_eq("disable_led", int'(led), 1);
        en = 1'b1;
        step();
        check_eq("reenable_hb", int'(state), 1);
        step();
        check_eq("reenable_err", int'(state), 3);

        // Random traffic against the model.
        err = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 39) == 0) err = ~err;
            act = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
